// File: rtl/lwn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lwn_pkg
// Purpose  : Shared definitions for the load-multiple (lwn) sequencer:
//            FSM state encoding, default data-path widths and the
//            register-file index width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lwn_pkg;

   // Default widths used as parameter defaults by the sequencer
   localparam int c_def_addr_w = 32;   // data-memory word-address width
   localparam int c_def_data_w = 32;   // data word width
   localparam int c_def_cnt_w  = 5;    // word-count field width (0..31)
   localparam int c_reg_idx_w  = 5;    // register-file index width (32 regs)

   // Sequencer FSM states
   //   IDLE : waiting for an accepted start
   //   RUN  : issuing one memory read per cycle (and writing the previous word)
   //   LAST : final register-file write only, done asserted
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LAST = 2'd2
   } lwn_state_e;

endpackage : lwn_pkg
`default_nettype wire

// File: rtl/lwn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lwn_sequencer
// Purpose  : Multi-cycle sequencer for the load-multiple instruction
//            "lwn rd, base, n". Reads n consecutive data-memory words starting
//            at base and writes them to n consecutive registers starting at rd.
//            Reads are issued in cycles 1..n after the accepting edge, each
//            word is written one cycle after its read, done pulses with the
//            last write, busy covers the whole operation.
//
// Ports    : clk            i  sole clock, rising edge
//            rst_n          i  synchronous active-low reset
//            start_i        i  one-cycle request (ignored while busy)
//            base_addr_i    i  first memory word index (sampled with start)
//            word_cnt_i     i  number of words n (sampled with start)
//            dest_idx_i     i  first destination register (sampled with start)
//            mem_rd_en_o    o  data-memory read strobe
//            mem_addr_o     o  data-memory word index
//            mem_rd_data_i  i  read data, valid one cycle after mem_rd_en_o
//            rf_we_o        o  register-file write enable (never for r0)
//            rf_waddr_o     o  register-file write index
//            rf_wdata_o     o  register-file write data
//            busy_o         o  sequencer active / pipeline stall
//            done_o         o  one-cycle completion pulse
//
// Revision : 1.0 - initial release
// ============================================================================
module lwn_sequencer
   import lwn_pkg::*;
#(
   parameter int ADDR_W = c_def_addr_w,
   parameter int DATA_W = c_def_data_w,
   parameter int CNT_W  = c_def_cnt_w
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_i,
   input  logic [ADDR_W-1:0]      base_addr_i,
   input  logic [CNT_W-1:0]       word_cnt_i,
   input  logic [c_reg_idx_w-1:0] dest_idx_i,
   output logic                   mem_rd_en_o,
   output logic [ADDR_W-1:0]      mem_addr_o,
   input  logic [DATA_W-1:0]      mem_rd_data_i,
   output logic                   rf_we_o,
   output logic [c_reg_idx_w-1:0] rf_waddr_o,
   output logic [DATA_W-1:0]      rf_wdata_o,
   output logic                   busy_o,
   output logic                   done_o
);

   // -------------------------------------------------------------------------
   // State and registered outputs
   // -------------------------------------------------------------------------
   lwn_state_e             state_q;
   logic [CNT_W:0]         rem_q;        // reads still to issue, incl. current
   logic [ADDR_W-1:0]      mem_addr_q;
   logic                   mem_rd_en_q;
   logic [c_reg_idx_w-1:0] wr_idx_q;     // destination of the word being read
   logic [c_reg_idx_w-1:0] rf_waddr_q;
   logic                   rf_we_q;
   logic                   wr_slot_q;    // a write slot is active this cycle
   logic                   busy_q;
   logic                   done_q;
   logic [DATA_W-1:0]      wdata_hold_q; // last write data, shown when idle

   // -------------------------------------------------------------------------
   // Increment logic (natural wrap: address mod 2^ADDR_W, index mod 32)
   // -------------------------------------------------------------------------
   logic [ADDR_W-1:0]      mem_addr_d;
   logic [c_reg_idx_w-1:0] wr_idx_d;
   logic [CNT_W:0]         rem_d;

   assign mem_addr_d = mem_addr_q + ADDR_W'(1);
   assign wr_idx_d   = wr_idx_q + c_reg_idx_w'(1);
   assign rem_d      = rem_q - (CNT_W+1)'(1);

   // -------------------------------------------------------------------------
   // Sequencer FSM with registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rem_q        <= '0;
         mem_addr_q   <= '0;
         mem_rd_en_q  <= 1'b0;
         wr_idx_q     <= '0;
         rf_waddr_q   <= '0;
         rf_we_q      <= 1'b0;
         wr_slot_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         wdata_hold_q <= '0;
      end else begin
         // Remember the data of every write slot so rf_wdata keeps its last
         // value once the sequencer goes quiet.
         if (wr_slot_q) begin
            wdata_hold_q <= mem_rd_data_i;
         end

         case (state_q)
            IDLE: begin
               mem_rd_en_q <= 1'b0;
               rf_we_q     <= 1'b0;
               wr_slot_q   <= 1'b0;
               done_q      <= 1'b0;
               if (start_i) begin
                  if (word_cnt_i != '0) begin
                     // Accept: operands are captured here and never again
                     // until the sequencer is back in IDLE.
                     state_q     <= RUN;
                     busy_q      <= 1'b1;
                     mem_rd_en_q <= 1'b1;
                     mem_addr_q  <= base_addr_i;
                     rem_q       <= {1'b0, word_cnt_i};
                     wr_idx_q    <= dest_idx_i;
                  end else begin
                     // Zero-length request: complete without any traffic
                     done_q <= 1'b1;
                  end
               end
            end

            RUN: begin
               // The read issued this cycle returns next cycle, so schedule
               // its register write now. r0 is never written, but the index
               // still advances.
               rf_waddr_q <= wr_idx_q;
               rf_we_q    <= (wr_idx_q != '0);
               wr_slot_q  <= 1'b1;
               wr_idx_q   <= wr_idx_d;
               rem_q      <= rem_d;
               if (rem_q == (CNT_W+1)'(1)) begin
                  // Final read has just been issued
                  state_q     <= LAST;
                  mem_rd_en_q <= 1'b0;
                  done_q      <= 1'b1;
               end else begin
                  mem_addr_q <= mem_addr_d;
               end
            end

            LAST: begin
               state_q   <= IDLE;
               busy_q    <= 1'b0;
               done_q    <= 1'b0;
               rf_we_q   <= 1'b0;
               wr_slot_q <= 1'b0;
            end

            default: begin
               state_q     <= IDLE;
               busy_q      <= 1'b0;
               done_q      <= 1'b0;
               mem_rd_en_q <= 1'b0;
               rf_we_q     <= 1'b0;
               wr_slot_q   <= 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs. Write data comes straight from memory during a write slot and
   // falls back to the held copy otherwise.
   // -------------------------------------------------------------------------
   assign mem_rd_en_o = mem_rd_en_q;
   assign mem_addr_o  = mem_addr_q;
   assign rf_we_o     = rf_we_q;
   assign rf_waddr_o  = rf_waddr_q;
   assign rf_wdata_o  = wr_slot_q ? mem_rd_data_i : wdata_hold_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule : lwn_sequencer
`default_nettype wire

// File: doc/lwn_sequencer.md
LWN_SEQUENCER -- requirements
Module: lwn_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, data-memory word-address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter CNT_W, default 5, width of word-count field (0..31 words).
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin load-multiple (lwn rd, base, n).
REQ-007 base_addr  input  ADDR_W  first data-memory word index, sampled with start.
REQ-008 word_cnt  input  CNT_W  number of words n, sampled with start.
REQ-009 dest_idx  input  5  first destination register index, sampled with start.
REQ-010 mem_rd_en  output  1  data-memory read strobe.
REQ-011 mem_addr  output  ADDR_W  data-memory word index for current read.
REQ-012 mem_rd_data  input  DATA_W  read data, valid exactly one cycle after mem_rd_en.
REQ-013 rf_we  output  1  register-file write enable.
REQ-014 rf_waddr  output  5  register-file write index.
REQ-015 rf_wdata  output  DATA_W  register-file write data.
REQ-016 busy  output  1  sequencer active; pipeline stall request.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 States: IDLE, RUN, LAST; single FSM, encoding from shared package.
REQ-019 IDLE: start sampled at edge E0 with word_cnt>0 -> RUN; word_cnt==0 -> stay IDLE, done pulsed in cycle after E0, no mem/rf activity.
REQ-020 RUN cycle k (k=0..n-1 after E0): mem_rd_en=1, mem_addr=base_addr+k, modulo 2^ADDR_W.
REQ-021 Write for word k occurs in cycle k+1: rf_we=1, rf_waddr=(dest_idx+k) mod 32, rf_wdata=mem_rd_data (direct from memory, no extra register).
REQ-022 RUN -> LAST after issuing read n-1; LAST performs final write only (mem_rd_en=0), asserts done, -> IDLE.
REQ-023 Total: n reads in cycles 1..n, n writes in cycles 2..n+1, done in cycle n+1, busy high cycles 1..n+1.
REQ-024 rf_waddr==0 computed: rf_we forced 0 for that word (r0 never written), counters still advance.
REQ-025 start while busy=1 (including LAST cycle) ignored; no re-sampling of inputs.
REQ-026 Inputs sampled only at accepted start; later changes on base_addr/word_cnt/dest_idx have no effect.
REQ-027 Outside defined active cycles mem_rd_en=0, rf_we=0, done=0; mem_addr, rf_waddr, rf_wdata hold last value.
REQ-028 Internal remaining-word counter CNT_W+1 bits wide; no underflow at n=31.

Reset
REQ-029 rst_n=0 at a rising edge: state=IDLE, busy=0, done=0, mem_rd_en=0, rf_we=0, mem_addr=0, rf_waddr=0, counters=0.
REQ-030 Reset mid-operation aborts immediately; no further reads/writes, no done pulse; partial writes not undone.
REQ-031 start coincident with rst_n=0 ignored.

Structure
REQ-032 Shared package lwn_pkg: state enum (IDLE, RUN, LAST), default widths ADDR_W/DATA_W/CNT_W, register-index width 5.
REQ-033 Single module; no sub-module required; address and index increment logic inline.

Verification
REQ-034 dataMem[3..6]=11,22,33,44; start base=3, n=4, dest=4 -> reads addr 3..6 cycles 1..4; writes r4..r7=11,22,33,44 cycles 2..5; done cycle 5.
REQ-035 start n=0 -> done in cycle 1; mem_rd_en, rf_we, busy never asserted.
REQ-036 base=10, n=3, dest=30 -> writes r30, r31 only; r0 slot rf_we=0; done cycle 4.
REQ-037 start re-asserted cycles 2 and 5 of n=4 run -> ignored; exactly 4 writes; start in cycle 6 accepted.
REQ-038 rst_n=0 in cycle 3 of n=4 run -> from next cycle all outputs at reset values; no done; r6, r7 unwritten.
REQ-039 base=0xFFFF_FFFE, n=3 -> mem_addr sequence FFFF_FFFE, FFFF_FFFF, 0000_0000.
